phase_ramp_acc: RTL and testbench
=================================

Name: phase_ramp_acc

Overview:
- Downstream consumer of the time controller's output time stream (sync, valid, t).
- Converts sample time into a chirped phase word: phase(t) = PHASE + FREQ*t + DFREQ*t*(t-1)/2 mod 2^BP, computed incrementally.
- Output phase word is truncated to BO MSBs and feeds the DDS/LUT stage, with t and valid delay-matched.

Parameters:
- B, 8, time word width; must match the upstream time controller's B.
- BP, 32, phase/frequency accumulator width.
- BO, 16, output phase width (MSBs of the accumulator); BO <= BP.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- sync  in  1  one-cycle pulse marking time origin; arrives in the same cycle as the first valid (t=0).
- valid  in  1  time sample valid; stays high while time is held.
- t_in  in  B  sample time; increments by 1 or holds.
- FREQ_REG  in  BP  start frequency (phase increment per time step), unsigned modulo 2^BP.
- DFREQ_REG  in  BP  frequency increment per time step, two's complement.
- PHASE_REG  in  BP  initial phase.
- valid_out  out  1  output valid.
- t_out  out  B  t_in delayed to align with phase_out.
- phase_out  out  BO  phase MSBs.
- err  out  1  sticky time-discontinuity flag.

Behaviour:
- Reset (rst=1 at a clk edge): FSM to IDLE_ST; accumulators, t_prev and pipeline cleared; valid_out=0, t_out=0, phase_out=0, err=0. Reset mid-run aborts with no further output.
- FSM states:
  - IDLE_ST: ignores valid without sync; valid_out stays 0. sync=1 -> RUN_ST.
  - RUN_ST: valid=0 -> IDLE_ST. sync=1 restarts in place (reload).
- Config capture: FREQ_REG, DFREQ_REG and PHASE_REG are sampled only on the sync cycle, into f_acc, df_r and ph_acc. Changes mid-run are ignored until the next sync.
- Sync cycle (sync=1, any state):
  - Sample emitted with phase = PHASE_REG.
  - Then ph_acc <= PHASE_REG + FREQ_REG.
  - f_acc <= FREQ_REG + DFREQ_REG.
  - t_prev <= t_in; err cleared.
- RUN_ST, valid=1, sync=0:
  - Step when t_in != t_prev: emit phase = ph_acc; then ph_acc += f_acc; f_acc += df_r; t_prev <= t_in.
  - Hold when t_in == t_prev: emit the phase of the last step again; accumulators frozen.
  - Discontinuity: on a step where t_in != t_prev+1 (mod 2^B), set err; perform one step anyway.
- Arithmetic: all adds modulo 2^BP with no saturation; f_acc wraps. phase_out = emitted phase[BP-1 -: BO], truncated, not rounded.
- Latency: 2 clk from input sample to outputs.
  - Stage 1 registers the emitted phase, t_in and accepted-valid.
  - Stage 2 registers the outputs.
  - valid_out, t_out and phase_out are mutually aligned.
  - valid_out = accepted-valid delayed by 2, where accepted-valid = valid & (sync | RUN_ST).
- sync with valid=0: a protocol error; config still loads, no sample emitted, FSM goes to RUN_ST and exits next cycle if valid stays low.
- t wrap: t_in going 2^B-1 -> 0 counts as a normal step, no err.
- err: updates in the stage-1 cycle and holds until the next sync or rst.

Decomposition:
- Shared package phase_ramp_pkg holds the state_t enum {IDLE_ST, RUN_ST} and the phase-slice helper function.
- One sub-module, ramp_accum: the ph_acc/f_acc pair with load/step/hold controls, reusable by other generators.
- The top level holds the FSM, t_prev/err logic and the output pipeline.

Test Plan:
- Constant tone: PHASE=0, FREQ=0x0100_0000, DFREQ=0; sync+valid with t=0..5 continuous -> phase_out 0x0000,0x0100,0x0200,...,0x0500 on valid_out, 2 clk after each input, t_out=0..5.
- Chirp: PHASE=0x1000_0000, FREQ=0x0100_0000, DFREQ=0x0010_0000; t=0..3 -> phase_out 0x1000,0x1100,0x1210,0x1330.
- Hold: t=0,1,1,1,2 with valid high and FREQ=0x0100_0000 -> phase_out 0x0000,0x0100,0x0100,0x0100,0x0200; valid_out high 5 cycles; err=0.
- Wrap/discontinuity:
  - FREQ=0xFF00_0000 over t=0..2 -> phase_out 0x0000,0xFF00,0xFE00.
  - Then t_in jumps 2->5 -> err=1 two cycles later, still set after valid drops; cleared by the next sync.
- Idle and ignore: valid=1 without sync in IDLE_ST -> valid_out=0. Changing FREQ_REG mid-run -> no effect until the next sync.
- Reset mid-run: rst=1 at t=3 -> next edge all outputs 0, FSM to IDLE_ST; subsequent valid without sync produces nothing.

Source files
------------

// File: rtl/phase_ramp_acc_pkg.sv
// Shared types and helpers for the chirped phase ramp generator.
package phase_ramp_pkg;

    typedef enum logic {IDLE_ST, RUN_ST} state_t;

    // Widest accumulator the slice helper supports.
    localparam int PH_MAX = 64;

    // Left-justify a bp-bit phase word in PH_MAX bits so callers can take
    // the output MSBs with a fixed part-select, whatever their BP is.
    function automatic logic [PH_MAX-1:0] phase_align(input logic [PH_MAX-1:0] ph,
                                                       input int unsigned     bp);
        return ph << (PH_MAX - bp);
    endfunction

endpackage

// File: rtl/phase_ramp_acc_if.sv
// Time-stream input, phase configuration and phase-word output of phase_ramp_acc.
interface phase_ramp_acc_if #(
    parameter int B  = 8,
    parameter int BP = 32,
    parameter int BO = 16
);
    logic          sync;
    logic          valid;
    logic [B-1:0]  t_in;
    logic [BP-1:0] FREQ_REG;
    logic [BP-1:0] DFREQ_REG;
    logic [BP-1:0] PHASE_REG;
    logic          valid_out;
    logic [B-1:0]  t_out;
    logic [BO-1:0] phase_out;
    logic          err;

    // Producer of time samples / consumer of phase words.
    modport master (
        output sync, valid, t_in, FREQ_REG, DFREQ_REG, PHASE_REG,
        input  valid_out, t_out, phase_out, err
    );

    // The phase ramp block itself.
    modport slave (
        input  sync, valid, t_in, FREQ_REG, DFREQ_REG, PHASE_REG,
        output valid_out, t_out, phase_out, err
    );
endinterface

// File: rtl/phase_ramp_acc_ramp_accum.sv
// Second-order phase accumulator: phase advances by freq, freq advances by dfreq.
// Load primes both so the first step after load yields ph0+f0+... directly.
module ramp_accum #(
    parameter int BP = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [BP-1:0] i_ph0,
    input  logic [BP-1:0] i_f0,
    input  logic [BP-1:0] i_df,
    output logic [BP-1:0] o_ph
);
    logic [BP-1:0] r_ph;
    logic [BP-1:0] r_f;
    logic [BP-1:0] r_df;

    // Load beats step; otherwise hold. All adds wrap modulo 2^BP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ph <= '0;
            r_f  <= '0;
            r_df <= '0;
        end else if (i_load) begin
            r_ph <= i_ph0 + i_f0;
            r_f  <= i_f0 + i_df;
            r_df <= i_df;
        end else if (i_step) begin
            r_ph <= r_ph + r_f;
            r_f  <= r_f + r_df;
        end
    end

    assign o_ph = r_ph;

endmodule

// File: rtl/phase_ramp_acc.sv
// Chirped phase generator driven by a time stream: FSM, time tracking,
// discontinuity flag and a two-stage output pipeline around ramp_accum.
module phase_ramp_acc
    import phase_ramp_pkg::*;
#(
    parameter int B  = 8,
    parameter int BP = 32,
    parameter int BO = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    phase_ramp_acc_if.slave      bus
);
    state_t        r_state;
    state_t        w_state_nxt;

    logic          w_acc_vld;
    logic          w_step;
    logic          w_disc;
    logic [BP-1:0] w_ph_acc;
    logic [BP-1:0] w_emit;

    logic [B-1:0]  r_t_prev;
    logic [BP-1:0] r_last_ph;
    logic          r_err;

    logic [2:1]    r_vld_pipe;
    logic [BP-1:0] r_s1_ph;
    logic [B-1:0]  r_s1_t;
    logic [B-1:0]  r_t_out;
    logic [BO-1:0] r_ph_out;

    logic [PH_MAX-1:0] w_ph_al;

    assign w_acc_vld = bus.valid & (bus.sync | (r_state == RUN_ST));
    assign w_step    = bus.valid & ~bus.sync & (r_state == RUN_ST) & (bus.t_in != r_t_prev);
    assign w_disc    = w_step & (bus.t_in != (r_t_prev + B'(1)));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE_ST;
        else     r_state <= w_state_nxt;
    end

    // Sync (re)starts from any state; losing valid drops back to idle.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.sync)
            w_state_nxt = RUN_ST;
        else if (r_state == RUN_ST && !bus.valid)
            w_state_nxt = IDLE_ST;
    end

    ramp_accum #(.BP(BP)) u_accum (
        .clk    (clk),
        .rst    (rst),
        .i_load (bus.sync),
        .i_step (w_step),
        .i_ph0  (bus.PHASE_REG),
        .i_f0   (bus.FREQ_REG),
        .i_df   (bus.DFREQ_REG),
        .o_ph   (w_ph_acc)
    );

    // Phase presented this cycle: config phase on sync, accumulator on a step,
    // otherwise repeat the last stepped phase (time holding).
    always_comb begin
        w_emit = r_last_ph;
        if (bus.sync)
            w_emit = bus.PHASE_REG;
        else if (w_step)
            w_emit = w_ph_acc;
    end

    // Time tracking, last emitted phase and sticky discontinuity flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_t_prev  <= '0;
            r_last_ph <= '0;
            r_err     <= 1'b0;
        end else if (bus.sync) begin
            r_t_prev  <= bus.t_in;
            r_last_ph <= bus.PHASE_REG;
            r_err     <= 1'b0;
        end else if (w_step) begin
            r_t_prev  <= bus.t_in;
            r_last_ph <= w_ph_acc;
            if (w_disc) r_err <= 1'b1;
        end
    end

    assign w_ph_al = phase_align(PH_MAX'(r_s1_ph), BP);

    // Stage 1 captures the emitted sample, stage 2 drives the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_s1_ph    <= '0;
            r_s1_t     <= '0;
            r_t_out    <= '0;
            r_ph_out   <= '0;
        end else begin
            r_vld_pipe[1] <= w_acc_vld;
            r_s1_ph       <= w_emit;
            r_s1_t        <= bus.t_in;
            r_vld_pipe[2] <= r_vld_pipe[1];
            r_t_out       <= r_s1_t;
            r_ph_out      <= w_ph_al[PH_MAX-1 -: BO];
        end
    end

    assign bus.valid_out = r_vld_pipe[2];
    assign bus.t_out     = r_t_out;
    assign bus.phase_out = r_ph_out;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_phase_ramp_acc.sv
// Scoreboard bench for phase_ramp_acc: directed time streams with
// hand-computed phase words, checked by an independent output monitor.
module tb_phase_ramp_acc;

    typedef struct {
        logic [7:0]  t;
        logic [15:0] ph;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;
    exp_t q[$];

    phase_ramp_acc_if #(.B(8), .BP(32), .BO(16)) u_if ();

    phase_ramp_acc #(.B(8), .BP(32), .BO(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cfg(input logic [31:0] p, input logic [31:0] f, input logic [31:0] d);
        u_if.PHASE_REG = p;
        u_if.FREQ_REG  = f;
        u_if.DFREQ_REG = d;
    endtask

    // Drive one cycle; queue the expected output sample when one is due.
    task automatic drv(input logic s, input logic v, input logic [7:0] tt,
                       input logic [15:0] eph, input bit push);
        u_if.sync  = s;
        u_if.valid = v;
        u_if.t_in  = tt;
        if (push) q.push_back('{t: tt, ph: eph});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
    endtask

    // Monitor: every presented output sample must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (u_if.valid_out === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_output t_out=%0d phase_out=%h required=no output",
                             u_if.t_out, u_if.phase_out);
                end else begin
                    e = q.pop_front();
                    chk("t_out", 64'(u_if.t_out), 64'(e.t));
                    chk("phase_out", 64'(u_if.phase_out), 64'(e.ph));
                end
            end
        end
    end

    initial begin
        u_if.sync = 1'b0;
        u_if.valid = 1'b0;
        u_if.t_in = '0;
        cfg(32'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_out", 64'(u_if.valid_out), 64'd0);
        chk("reset_t_out", 64'(u_if.t_out), 64'd0);
        chk("reset_phase_out", 64'(u_if.phase_out), 64'd0);
        chk("reset_err", 64'(u_if.err), 64'd0);
        rst = 1'b0;

        // Constant tone
        cfg(32'h0, 32'h0100_0000, 32'h0);
        drv(1, 1, 8'd0, 16'h0000, 1);
        for (int i = 1; i <= 5; i++) drv(0, 1, 8'(i), 16'(i * 16'h0100), 1);
        idle(3);

        // Chirp; mid-run config changes must be ignored
        cfg(32'h1000_0000, 32'h0100_0000, 32'h0010_0000);
        drv(1, 1, 8'd0, 16'h1000, 1);
        cfg(32'hDEAD_BEEF, 32'h7777_0000, 32'h0123_4567);
        drv(0, 1, 8'd1, 16'h1100, 1);
        drv(0, 1, 8'd2, 16'h1210, 1);
        drv(0, 1, 8'd3, 16'h1330, 1);
        idle(3);

        // Hold
        cfg(32'h0, 32'h0100_0000, 32'h0);
        drv(1, 1, 8'd0, 16'h0000, 1);
        drv(0, 1, 8'd1, 16'h0100, 1);
        drv(0, 1, 8'd1, 16'h0100, 1);
        drv(0, 1, 8'd1, 16'h0100, 1);
        drv(0, 1, 8'd2, 16'h0200, 1);
        idle(3);
        chk("hold_err", 64'(u_if.err), 64'd0);

        // Frequency wrap then discontinuity 2->5
        cfg(32'h0, 32'hFF00_0000, 32'h0);
        drv(1, 1, 8'd0, 16'h0000, 1);
        drv(0, 1, 8'd1, 16'hFF00, 1);
        drv(0, 1, 8'd2, 16'hFE00, 1);
        chk("pre_jump_err", 64'(u_if.err), 64'd0);
        drv(0, 1, 8'd5, 16'hFD00, 1);
        idle(3);
        chk("jump_err_sticky", 64'(u_if.err), 64'd1);

        // Sync clears err; time wraps 255->0 without err
        cfg(32'h0, 32'h0100_0000, 32'h0);
        drv(1, 1, 8'd254, 16'h0000, 1);
        chk("sync_clears_err", 64'(u_if.err), 64'd0);
        drv(0, 1, 8'd255, 16'h0100, 1);
        drv(0, 1, 8'd0, 16'h0200, 1);
        drv(0, 1, 8'd1, 16'h0300, 1);
        idle(3);
        chk("t_wrap_err", 64'(u_if.err), 64'd0);

        // Sync with valid low: config loads, no sample, next step uses loaded ramp
        cfg(32'h0001_0000, 32'h0200_0000, 32'h0);
        drv(1, 0, 8'd9, 16'h0, 0);
        drv(0, 1, 8'd10, 16'h0201, 1);
        drv(0, 1, 8'd11, 16'h0401, 1);
        idle(3);

        // Valid without sync in idle is ignored
        drv(0, 1, 8'd7, 16'h0, 0);
        drv(0, 1, 8'd8, 16'h0, 0);
        drv(0, 1, 8'd9, 16'h0, 0);
        chk("idle_ignore_valid_out", 64'(u_if.valid_out), 64'd0);
        idle(2);

        // Reset mid-run: samples in flight at the reset edge are dropped
        cfg(32'h0, 32'h0100_0000, 32'h0);
        drv(1, 1, 8'd0, 16'h0000, 1);
        drv(0, 1, 8'd1, 16'h0100, 1);
        drv(0, 1, 8'd2, 16'h0200, 0);
        rst = 1'b1;
        drv(0, 1, 8'd3, 16'h0300, 0);
        chk("midrst_valid_out", 64'(u_if.valid_out), 64'd0);
        chk("midrst_t_out", 64'(u_if.t_out), 64'd0);
        chk("midrst_phase_out", 64'(u_if.phase_out), 64'd0);
        chk("midrst_err", 64'(u_if.err), 64'd0);
        rst = 1'b0;
        drv(0, 1, 8'd4, 16'h0, 0);
        drv(0, 1, 8'd5, 16'h0, 0);
        drv(0, 1, 8'd6, 16'h0, 0);
        chk("post_rst_valid_out", 64'(u_if.valid_out), 64'd0);
        idle(2);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
